// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a single-port 16x4 SRAM
module ram_fifo_ctrl #(
    parameter int DW    = 4,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_wr,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPT} state_t;

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Pop wins a same-cycle contest, hence the pop -> push_ready path.
    assign pop_ready  = (state == IDLE) && !empty;
    assign push_ready = (state == IDLE) && !full && !(pop && !empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ram_wr    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop && pop_ready) begin
                        state    <= READ;
                        ram_rd   <= 1'b1;
                        ram_addr <= rptr;
                    end else if (push && push_ready) begin
                        state    <= WRITE;
                        ram_wr   <= 1'b1;
                        ram_addr <= wptr;
                        ram_din  <= push_data;
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    ram_wr <= 1'b0;
                    wptr   <= wptr + 1'b1;
                    count  <= count + 1'b1;
                end
                READ: begin
                    state  <= CAPT;
                    ram_rd <= 1'b0;
                end
                CAPT: begin
                    // SRAM Out was loaded on the READ exit edge and is stable here.
                    state     <= IDLE;
                    pop_data  <= ram_dout;
                    pop_valid <= 1'b1;
                    rptr      <= rptr + 1'b1;
                    count     <= count - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - randomized self-checking bench for ram_fifo_ctrl
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop;
    logic [3:0] push_data;
    logic       push_ready, pop_ready, pop_valid;
    logic [3:0] pop_data;
    logic       full, empty;
    logic [4:0] count;
    logic       ram_wr, ram_rd;
    logic [3:0] ram_addr, ram_din, ram_dout;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] q[$];
    int         mwptr, mrptr;

    ram_fifo_ctrl #(.DW(4), .AW(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_data(pop_data),
        .full(full), .empty(empty), .count(count),
        .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: RD has priority, a write floats Out.
    logic [3:0] mem [16];
    logic [3:0] sram_out;
    assign ram_dout = sram_out;
    always @(posedge clk) begin
        if (ram_rd) sram_out <= mem[ram_addr];
        else if (ram_wr) begin
            mem[ram_addr] <= ram_din;
            sram_out      <= 4'bz;
        end
    end

    always @(negedge clk) begin
        if (!rst && ram_wr && ram_rd) begin
            compared++; mismatched++;
            $display("FAIL pin_overlap: ram_wr=%b ram_rd=%b required not both 1", ram_wr, ram_rd);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        tick(); tick();
        rst = 1'b0;
        q.delete(); mwptr = 0; mrptr = 0;
    endtask

    task automatic do_push(input logic [3:0] d, output bit ok, output logic [3:0] a,
                           output logic [3:0] dn, output int wr_len);
        ok = 0; a = '0; dn = '0; wr_len = 0;
        push = 1'b1; push_data = d; #1;
        for (int i = 0; i < 40; i++) begin
            if (push_ready) begin ok = 1; break; end
            tick();
        end
        if (ok) begin
            tick();
            push = 1'b0;
            a = ram_addr; dn = ram_din; wr_len = int'(ram_wr);
            tick();
            wr_len += int'(ram_wr);
            q.push_back(d); mwptr++;
        end
        push = 1'b0;
    endtask

    task automatic do_pop(output bit ok, output logic [3:0] a, output logic [3:0] d,
                          output int rd_len, output int lat);
        ok = 0; a = '0; d = 'x; rd_len = 0; lat = 0;
        pop = 1'b1; #1;
        for (int i = 0; i < 40; i++) begin
            if (pop_ready) begin ok = 1; break; end
            tick();
        end
        if (ok) begin
            tick();
            pop = 1'b0;
            a = ram_addr; rd_len = int'(ram_rd);
            for (int k = 1; k <= 8; k++) begin
                if (k == 2) rd_len += int'(ram_rd);
                if (pop_valid) begin lat = k; d = pop_data; break; end
                tick();
            end
            void'(q.pop_front()); mrptr++;
        end
        pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; #1;
        compared += 9;
        if (ram_wr !== 1'b0)    begin mismatched++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
        if (ram_rd !== 1'b0)    begin mismatched++; $display("FAIL reset_ram_rd: got %b want 0", ram_rd); end
        if (empty !== 1'b1)     begin mismatched++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0)      begin mismatched++; $display("FAIL reset_full: got %b want 0", full); end
        if (count !== 5'd0)     begin mismatched++; $display("FAIL reset_count: got %0d want 0", count); end
        if (pop_valid !== 1'b0) begin mismatched++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
        if (pop_data !== 4'h0)  begin mismatched++; $display("FAIL reset_pop_data: got %h want 0", pop_data); end
        if (ram_addr !== 4'h0)  begin mismatched++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        if (ram_din !== 4'h0)   begin mismatched++; $display("FAIL reset_ram_din: got %h want 0", ram_din); end
        tick(); rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok; logic [3:0] a, dn, d; int wl, rl, lat;
        do_reset();
        do_push(4'hA, ok, a, dn, wl);
        compared += 5;
        if (ok !== 1'b1)    begin mismatched++; $display("FAIL basic_push_timeout: got %b want 1", ok); end
        if (a !== 4'h0)     begin mismatched++; $display("FAIL basic_wr_addr: got %h want 0", a); end
        if (dn !== 4'hA)    begin mismatched++; $display("FAIL basic_wr_din: got %h want a", dn); end
        if (wl !== 1)       begin mismatched++; $display("FAIL basic_wr_len: got %0d want 1", wl); end
        if (count !== 5'd1) begin mismatched++; $display("FAIL basic_count: got %0d want 1", count); end
        do_pop(ok, a, d, rl, lat);
        compared += 5;
        if (a !== 4'h0)      begin mismatched++; $display("FAIL basic_rd_addr: got %h want 0", a); end
        if (rl !== 1)        begin mismatched++; $display("FAIL basic_rd_len: got %0d want 1", rl); end
        if (lat !== 3)       begin mismatched++; $display("FAIL basic_pop_latency: got %0d want 3", lat); end
        if (d !== 4'hA)      begin mismatched++; $display("FAIL basic_pop_data: got %h want a", d); end
        if (empty !== 1'b1)  begin mismatched++; $display("FAIL basic_empty: got %b want 1", empty); end
    endtask

    task automatic test_fill();
        bit ok, seen; logic [3:0] a, dn, d; int wl, rl, lat;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_push(4'(i), ok, a, dn, wl);
            compared++;
            if (a !== 4'(i) || dn !== 4'(i) || ok !== 1'b1)
                begin mismatched++; $display("FAIL fill_push%0d: addr %h din %h want %h", i, a, dn, 4'(i)); end
        end
        compared += 3;
        if (full !== 1'b1)       begin mismatched++; $display("FAIL fill_full: got %b want 1", full); end
        if (push_ready !== 1'b0) begin mismatched++; $display("FAIL fill_push_ready: got %b want 0", push_ready); end
        if (count !== 5'd16)     begin mismatched++; $display("FAIL fill_count: got %0d want 16", count); end
        seen = 0; push = 1'b1; push_data = 4'h5;
        for (int i = 0; i < 4; i++) begin
            #1; if (push_ready || ram_wr) seen = 1;
            tick();
        end
        push = 1'b0;
        compared += 2;
        if (seen !== 1'b0)   begin mismatched++; $display("FAIL fill_17th_accepted: got %b want 0", seen); end
        if (count !== 5'd16) begin mismatched++; $display("FAIL fill_17th_count: got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            do_pop(ok, a, d, rl, lat);
            compared++;
            if (d !== 4'(i) || a !== 4'(i))
                begin mismatched++; $display("FAIL fill_pop%0d: data %h addr %h want %h", i, d, a, 4'(i)); end
        end
        seen = 0; pop = 1'b1; #1;
        if (pop_ready) seen = 1;
        tick(); tick();
        if (ram_rd) seen = 1;
        pop = 1'b0;
        compared += 2;
        if (empty !== 1'b1) begin mismatched++; $display("FAIL fill_empty: got %b want 1", empty); end
        if (seen !== 1'b0)  begin mismatched++; $display("FAIL fill_pop_when_empty: got %b want 0", seen); end
    endtask

    task automatic test_wrap();
        bit ok; logic [3:0] a, dn, d, ed; int wl, rl, lat;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_push(4'($urandom), ok, a, dn, wl);
            do_pop(ok, a, d, rl, lat);
        end
        for (int i = 0; i < 10; i++) begin
            do_push(4'($urandom), ok, a, dn, wl);
            compared++;
            if (a !== 4'((10 + i) % 16))
                begin mismatched++; $display("FAIL wrap_wr_addr%0d: got %h want %h", i, a, 4'((10 + i) % 16)); end
        end
        for (int i = 0; i < 10; i++) begin
            ed = q[0];
            do_pop(ok, a, d, rl, lat);
            compared++;
            if (d !== ed || a !== 4'((10 + i) % 16))
                begin mismatched++; $display("FAIL wrap_pop%0d: data %h addr %h want %h @%h", i, d, a, ed, 4'((10 + i) % 16)); end
        end
    endtask

    task automatic test_priority();
        bit ok, got; logic [3:0] a, dn, d, ed, r; int wl;
        do_reset();
        for (int i = 0; i < 3; i++) do_push(4'($urandom), ok, a, dn, wl);
        ed = q[0]; r = 4'($urandom);
        push = 1'b1; push_data = r; pop = 1'b1; #1;
        compared += 2;
        if (pop_ready !== 1'b1)  begin mismatched++; $display("FAIL prio_pop_ready: got %b want 1", pop_ready); end
        if (push_ready !== 1'b0) begin mismatched++; $display("FAIL prio_push_ready: got %b want 0", push_ready); end
        tick(); pop = 1'b0;
        compared += 2;
        if (ram_rd !== 1'b1 || ram_wr !== 1'b0) begin mismatched++; $display("FAIL prio_grant: rd %b wr %b want rd 1 wr 0", ram_rd, ram_wr); end
        if (count !== 5'd3) begin mismatched++; $display("FAIL prio_count_mid: got %0d want 3", count); end
        got = 0;
        for (int k = 0; k < 8; k++) begin
            if (pop_valid) begin got = 1; break; end
            tick();
        end
        void'(q.pop_front()); mrptr++;
        compared += 3;
        if (got !== 1'b1 || pop_data !== ed) begin mismatched++; $display("FAIL prio_pop_data: valid %b data %h want %h", got, pop_data, ed); end
        if (count !== 5'd2)      begin mismatched++; $display("FAIL prio_count_after_pop: got %0d want 2", count); end
        if (push_ready !== 1'b1) begin mismatched++; $display("FAIL prio_push_ready_after: got %b want 1", push_ready); end
        tick(); push = 1'b0;
        compared++;
        if (ram_wr !== 1'b1 || ram_din !== r || ram_addr !== 4'd3)
            begin mismatched++; $display("FAIL prio_push: wr %b din %h addr %h want 1 %h 3", ram_wr, ram_din, ram_addr, r); end
        q.push_back(r); mwptr++;
        tick();
        compared++;
        if (count !== 5'd3) begin mismatched++; $display("FAIL prio_count_final: got %0d want 3", count); end
    endtask

    task automatic test_reset_in_read();
        bit ok, seen; logic [3:0] a, dn, d, r; int wl, rl, lat;
        do_reset();
        do_push(4'($urandom), ok, a, dn, wl);
        do_push(4'($urandom), ok, a, dn, wl);
        pop = 1'b1; #1; tick(); pop = 1'b0;
        compared++;
        if (ram_rd !== 1'b1) begin mismatched++; $display("FAIL rstread_in_read: got %b want 1", ram_rd); end
        rst = 1'b1; #1;
        compared += 3;
        if (ram_rd !== 1'b0)    begin mismatched++; $display("FAIL rstread_ram_rd: got %b want 0", ram_rd); end
        if (count !== 5'd0)     begin mismatched++; $display("FAIL rstread_count: got %0d want 0", count); end
        if (empty !== 1'b1)     begin mismatched++; $display("FAIL rstread_empty: got %b want 1", empty); end
        tick(); rst = 1'b0;
        q.delete(); mwptr = 0; mrptr = 0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (pop_valid) seen = 1;
            tick();
        end
        compared++;
        if (seen !== 1'b0) begin mismatched++; $display("FAIL rstread_stray_valid: got %b want 0", seen); end
        r = 4'($urandom);
        do_push(r, ok, a, dn, wl);
        do_pop(ok, a, d, rl, lat);
        compared++;
        if (a !== 4'h0 || d !== r) begin mismatched++; $display("FAIL rstread_new_data: addr %h data %h want 0 %h", a, d, r); end
    endtask

    task automatic test_random();
        bit ok; logic [3:0] a, dn, d, ed, ea; int wl, rl, lat; bit do_p;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            do_p = (n < 60) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            if (do_p) begin
                if (q.size() == 16) begin
                    push = 1'b1; #1;
                    compared++;
                    if (push_ready !== 1'b0) begin mismatched++; $display("FAIL rand_push_full%0d: ready %b want 0", n, push_ready); end
                    tick(); push = 1'b0;
                end else begin
                    ea = 4'(mwptr % 16);
                    do_push(4'($urandom), ok, a, dn, wl);
                    compared++;
                    if (ok !== 1'b1 || a !== ea || count !== 5'(q.size()))
                        begin mismatched++; $display("FAIL rand_push%0d: addr %h count %0d want %h %0d", n, a, count, ea, q.size()); end
                end
            end else begin
                if (q.size() == 0) begin
                    pop = 1'b1; #1;
                    compared++;
                    if (pop_ready !== 1'b0) begin mismatched++; $display("FAIL rand_pop_empty%0d: ready %b want 0", n, pop_ready); end
                    tick(); pop = 1'b0;
                end else begin
                    ed = q[0]; ea = 4'(mrptr % 16);
                    do_pop(ok, a, d, rl, lat);
                    compared++;
                    if (d !== ed || a !== ea || lat !== 3)
                        begin mismatched++; $display("FAIL rand_pop%0d: data %h addr %h lat %0d want %h %h 3", n, d, a, lat, ed, ea); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_priority();
        test_reset_in_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
